// File: rtl/alu_dual_issue_sched.sv
// In-order dual-issue scheduler: dispatch FIFO -> ALU drive registers (E) -> writeback registers (W).
// Handshake: an op is taken on in_valid & in_ready; both W ports retire together on wb_ready.
module alu_dual_issue_sched #(
    parameter int OPE   = 32,
    parameter int FUNC  = 17,
    parameter int TAG   = 5,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAG-1:0]           in_tag,
    input  logic [OPE-1:0]           in_op1,
    input  logic [OPE-1:0]           in_op2,
    input  logic [FUNC-1:0]          in_func,
    output logic [OPE-1:0]           operand11,
    output logic [OPE-1:0]           operand12,
    output logic [FUNC-1:0]          op_func1,
    input  logic [OPE-1:0]           result1,
    output logic [OPE-1:0]           operand21,
    output logic [OPE-1:0]           operand22,
    output logic [FUNC-1:0]          op_func2,
    input  logic [OPE-1:0]           result2,
    output logic                     wb1_valid,
    output logic [TAG-1:0]           wb1_tag,
    output logic [OPE-1:0]           wb1_data,
    output logic                     wb2_valid,
    output logic [TAG-1:0]           wb2_tag,
    output logic [OPE-1:0]           wb2_data,
    input  logic                     wb_ready,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [TAG-1:0]  tag;
        logic [OPE-1:0]  op1;
        logic [OPE-1:0]  op2;
        logic [FUNC-1:0] func;
    } op_t;

    op_t            mem [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr, rd_ptr_p1;
    logic [CW-1:0]  count, npop;
    op_t            e1, e2, head0, head1;
    logic           e1_valid, e2_valid;
    logic           w1_valid, w2_valid;
    logic [TAG-1:0] w1_tag, w2_tag;
    logic [OPE-1:0] w1_data, w2_data;
    logic           push, adv;

    assign in_ready = (count < CW'(DEPTH));

    always_comb begin
        adv       = !(w1_valid | w2_valid) | wb_ready;
        push      = in_valid & in_ready & !flush;
        npop      = '0;
        if (adv) begin
            npop = (count >= CW'(2)) ? CW'(2) : count;
        end
        rd_ptr_p1 = rd_ptr + PW'(1);
        head0     = mem[rd_ptr];
        head1     = mem[rd_ptr_p1];
    end

    // Storage has no reset: entries are only read below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tag: in_tag, op1: in_op1, op2: in_op2, func: in_func};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            e1       <= '0;
            e2       <= '0;
            e1_valid <= 1'b0;
            e2_valid <= 1'b0;
            w1_valid <= 1'b0;
            w2_valid <= 1'b0;
            w1_tag   <= '0;
            w2_tag   <= '0;
            w1_data  <= '0;
            w2_data  <= '0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            e1       <= '0;
            e2       <= '0;
            e1_valid <= 1'b0;
            e2_valid <= 1'b0;
            w1_valid <= 1'b0;
            w2_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr + PW'(npop);
            count  <= count + CW'(push) - npop;
            // Empty E slots carry all-zero operands so the ALU sees a harmless func 0.
            if (adv) begin
                w1_valid <= e1_valid;
                w1_tag   <= e1.tag;
                w1_data  <= e1_valid ? result1 : '0;
                w2_valid <= e2_valid;
                w2_tag   <= e2.tag;
                w2_data  <= e2_valid ? result2 : '0;
                e1_valid <= (npop != '0);
                e1       <= (npop != '0) ? head0 : '0;
                e2_valid <= (npop == CW'(2));
                e2       <= (npop == CW'(2)) ? head1 : '0;
            end
        end
    end

    assign operand11  = e1.op1;
    assign operand12  = e1.op2;
    assign op_func1   = e1.func;
    assign operand21  = e2.op1;
    assign operand22  = e2.op2;
    assign op_func2   = e2.func;
    assign wb1_valid  = w1_valid;
    assign wb1_tag    = w1_tag;
    assign wb1_data   = w1_data;
    assign wb2_valid  = w2_valid;
    assign wb2_tag    = w2_tag;
    assign wb2_data   = w2_data;
    assign fifo_count = count;

endmodule

// File: tb/tb_alu_dual_issue_sched.sv
// Bench for alu_dual_issue_sched: a queue-level model of FIFO, E and W stages checked every cycle,
// plus directed scenarios for latency, pairing, full, flush and async reset.
module tb_alu_dual_issue_sched;
  localparam int OPE   = 32;
  localparam int FUNC  = 17;
  localparam int TAG   = 5;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam logic [FUNC-1:0] F_ADD = 17'h00001;
  localparam logic [FUNC-1:0] F_SUB = 17'h00002;
  localparam logic [FUNC-1:0] F_AND = 17'h00004;
  localparam logic [FUNC-1:0] F_OR  = 17'h00008;
  localparam logic [FUNC-1:0] F_XOR = 17'h00010;

  logic            clk, rst_n, flush, in_valid, in_ready, wb_ready;
  logic [TAG-1:0]  in_tag, wb1_tag, wb2_tag;
  logic [OPE-1:0]  in_op1, in_op2, operand11, operand12, operand21, operand22;
  logic [OPE-1:0]  result1, result2, wb1_data, wb2_data;
  logic [FUNC-1:0] in_func, op_func1, op_func2;
  logic            wb1_valid, wb2_valid;
  logic [CW-1:0]   fifo_count;

  alu_dual_issue_sched #(.OPE(OPE), .FUNC(FUNC), .TAG(TAG), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_op1(in_op1), .in_op2(in_op2), .in_func(in_func),
    .operand11(operand11), .operand12(operand12), .op_func1(op_func1), .result1(result1),
    .operand21(operand21), .operand22(operand22), .op_func2(op_func2), .result2(result2),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
    .wb2_valid(wb2_valid), .wb2_tag(wb2_tag), .wb2_data(wb2_data),
    .wb_ready(wb_ready), .fifo_count(fifo_count)
  );

  function automatic logic [OPE-1:0] alu(input logic [OPE-1:0] a, input logic [OPE-1:0] b,
                                         input logic [FUNC-1:0] f);
    case (f)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_XOR:   return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign result1 = alu(operand11, operand12, op_func1);
  assign result2 = alu(operand21, operand22, op_func2);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: ops waiting in the FIFO, in E, and in W, oldest first
  typedef struct packed {
    logic [TAG-1:0]  tag;
    logic [OPE-1:0]  a;
    logic [OPE-1:0]  b;
    logic [FUNC-1:0] f;
    logic [OPE-1:0]  res;
  } mop_t;

  mop_t fifo_m[$];
  mop_t e_m[$];
  mop_t w_m[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_wb    = 0;
  int   n_acc   = 0;
  logic [FUNC-1:0] funcs [5] = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR};

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check_eq("in_ready", 64'(in_ready), 64'(fifo_m.size() < DEPTH));
    check_eq("fifo_count", 64'(fifo_count), 64'(fifo_m.size()));
    check_eq("wb1_valid", 64'(wb1_valid), 64'(w_m.size() >= 1));
    check_eq("wb2_valid", 64'(wb2_valid), 64'(w_m.size() == 2));
    if (w_m.size() >= 1) begin
      check_eq("wb1_tag", 64'(wb1_tag), 64'(w_m[0].tag));
      check_eq("wb1_data", 64'(wb1_data), 64'(w_m[0].res));
    end
    if (w_m.size() == 2) begin
      check_eq("wb2_tag", 64'(wb2_tag), 64'(w_m[1].tag));
      check_eq("wb2_data", 64'(wb2_data), 64'(w_m[1].res));
    end
    if (e_m.size() >= 1) begin
      check_eq("slot1", {operand11, 15'd0, op_func1}, {e_m[0].a, 15'd0, e_m[0].f});
      check_eq("operand12", 64'(operand12), 64'(e_m[0].b));
    end else begin
      check_eq("slot1_idle", {operand11, operand12}, 64'd0);
      check_eq("func1_idle", 64'(op_func1), 64'd0);
    end
    if (e_m.size() == 2) begin
      check_eq("slot2", {operand21, 15'd0, op_func2}, {e_m[1].a, 15'd0, e_m[1].f});
      check_eq("operand22", 64'(operand22), 64'(e_m[1].b));
    end else begin
      check_eq("slot2_idle", {operand21, operand22}, 64'd0);
      check_eq("func2_idle", 64'(op_func2), 64'd0);
    end
  endtask

  // One clock: check registered outputs at negedge, advance the model with the current inputs.
  task automatic step();
    mop_t n;
    logic acc;
    @(negedge clk);
    check_state();
    if (flush) begin
      fifo_m.delete();
      e_m.delete();
      w_m.delete();
    end else begin
      acc = in_valid && (fifo_m.size() < DEPTH);
      if (w_m.size() == 0 || wb_ready) begin
        n_wb += w_m.size();
        w_m = e_m;
        e_m.delete();
        for (int i = 0; i < 2; i++)
          if (fifo_m.size() > 0) e_m.push_back(fifo_m.pop_front());
      end
      if (acc) begin
        n.tag = in_tag;
        n.a   = in_op1;
        n.b   = in_op2;
        n.f   = in_func;
        n.res = alu(in_op1, in_op2, in_func);
        fifo_m.push_back(n);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic push_op(input logic [TAG-1:0] t, input logic [OPE-1:0] a,
                         input logic [OPE-1:0] b, input logic [FUNC-1:0] f);
    in_valid = 1'b1;
    in_tag   = t;
    in_op1   = a;
    in_op2   = b;
    in_func  = f;
    step();
  endtask

  task automatic push_rand(input logic [TAG-1:0] t);
    push_op(t, $urandom, $urandom, funcs[$urandom_range(0, 4)]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int wb0, acc0;
    logic [TAG-1:0] tag_ctr;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    in_tag = '0; in_op1 = '0; in_op2 = '0; in_func = '0;
    tag_ctr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_count", 64'(fifo_count), 64'd0);
    check_eq("rst_valids", {62'd0, wb1_valid, wb2_valid}, 64'd0);
    check_eq("rst_wb_tags", {54'd0, wb1_tag, wb2_tag}, 64'd0);
    check_eq("rst_wb_data", {wb1_data, wb2_data}, 64'd0);
    check_eq("rst_alu", {operand11, operand21}, 64'd0);
    rst_n = 1'b1;

    // single op latency
    push_op(5'd3, 32'd5, 32'd7, F_ADD);
    idle(1);
    check_eq("t1_operand11", 64'(operand11), 64'd5);
    check_eq("t1_func1", 64'(op_func1), 64'(F_ADD));
    idle(1);
    check_eq("t1_wb1", {31'd0, wb1_valid, 27'd0, wb1_tag}, {31'd0, 1'b1, 27'd0, 5'd3});
    check_eq("t1_wb1_data", 64'(wb1_data), 64'd12);
    check_eq("t1_wb2_valid", 64'(wb2_valid), 64'd0);
    idle(2);

    // pair issue: an op held in W lets tags 1,2 gather in the FIFO and issue together
    wb_ready = 1'b0;
    push_op(5'd20, 32'd1, 32'd1, F_OR);
    idle(1);
    push_op(5'd1, 32'd10, 32'd20, F_ADD);
    push_op(5'd2, 32'd9, 32'd4, F_SUB);
    wb_ready = 1'b1;
    idle(1);
    check_eq("t2_operand11", 64'(operand11), 64'd10);
    check_eq("t2_operand21", 64'(operand21), 64'd9);
    check_eq("t2_func2", 64'(op_func2), 64'(F_SUB));
    idle(1);
    check_eq("t2_wb_tags", {54'd0, wb1_tag, wb2_tag}, {54'd0, 5'd1, 5'd2});
    check_eq("t2_wb_valids", {62'd0, wb1_valid, wb2_valid}, 64'd3);
    check_eq("t2_wb_data", {wb1_data, wb2_data}, {32'd30, 32'd5});
    idle(2);

    // full FIFO under backpressure, then in-order drain
    wb0 = n_wb; acc0 = n_acc;
    wb_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      push_rand(tag_ctr);
      tag_ctr++;
    end
    check_eq("t3_count_full", 64'(fifo_count), 64'(DEPTH));
    check_eq("t3_in_ready", 64'(in_ready), 64'd0);
    wb_ready = 1'b1;
    idle(10);
    check_eq("t3_drained", 64'(n_wb - wb0), 64'(n_acc - acc0));
    check_eq("t3_count_empty", 64'(fifo_count), 64'd0);

    // random traffic with wrap
    for (int i = 0; i < 400; i++) begin
      wb_ready = ($urandom_range(0, 99) < 55);
      if ($urandom_range(0, 99) < 70) begin
        push_rand(tag_ctr);
        tag_ctr++;
      end else begin
        idle(1);
      end
    end
    wb_ready = 1'b1;
    idle(6);
    check_eq("t4_all_retired", 64'(n_wb), 64'(n_acc));

    // flush with FIFO=5, E and W occupied, W held; a push in the flush cycle is dropped too
    wb_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push_rand(tag_ctr);
      tag_ctr++;
    end
    check_eq("t5_count5", 64'(fifo_count), 64'd5);
    check_eq("t5_w_held", 64'(wb1_valid), 64'd1);
    flush = 1'b1;
    push_rand(tag_ctr);
    flush = 1'b0;
    check_eq("t5_count0", 64'(fifo_count), 64'd0);
    check_eq("t5_valids0", {62'd0, wb1_valid, wb2_valid}, 64'd0);
    check_eq("t5_alu0", {operand11, 15'd0, op_func1}, 64'd0);
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check_eq("t5_no_wb", {62'd0, wb1_valid, wb2_valid}, 64'd0);
    end

    // asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) begin
      wb_ready = ($urandom_range(0, 1) == 1);
      push_rand(tag_ctr);
      tag_ctr++;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_count", 64'(fifo_count), 64'd0);
    check_eq("t6_valids", {62'd0, wb1_valid, wb2_valid}, 64'd0);
    check_eq("t6_alu", {operand11, operand21}, 64'd0);
    check_eq("t6_wb", {wb1_data, 27'd0, wb1_tag}, 64'd0);
    check_eq("t6_in_ready", 64'(in_ready), 64'd1);
    fifo_m.delete();
    e_m.delete();
    w_m.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wb_ready = 1'b1;
    push_op(5'd9, 32'd100, 32'd1, F_SUB);
    idle(2);
    check_eq("t6_wb1_tag9", {31'd0, wb1_valid, 27'd0, wb1_tag}, {31'd0, 1'b1, 27'd0, 5'd9});
    check_eq("t6_wb1_data", 64'(wb1_data), 64'd99);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
